// File: rtl/bp_resolve_if.sv
// Fetch/execute/predictor-update bundle for the branch-resolution tracker.
interface bp_resolve_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             push_valid;
    logic [IDX_W-1:0] push_idx;
    logic             push_pred;
    logic             push_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic [IDX_W-1:0] upd_addr;
    logic             upd_taken;
    logic             upd_we;
    logic             mispredict;
    logic [CNT_W-1:0] count;

    // Fetch/execute side: drives branches and outcomes, watches updates.
    modport master (
        output push_valid, push_idx, push_pred, res_valid, res_taken,
        input  push_ready, res_ready, upd_addr, upd_taken, upd_we, mispredict, count
    );

    // Tracker side.
    modport slave (
        input  push_valid, push_idx, push_pred, res_valid, res_taken,
        output push_ready, res_ready, upd_addr, upd_taken, upd_we, mispredict, count
    );
endinterface

// File: rtl/bp_resolve.sv
// In-order branch-resolution tracker: queues predictions, trains the
// predictor on resolve and flushes wrong-path entries on a mispredict.
module bp_resolve #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    bp_resolve_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt_c;

    logic [IDX_W-1:0] upd_addr_q;
    logic             upd_taken_q;
    logic             upd_we_q;
    logic             mispredict_q;

    entry_t           head_c;
    logic             push_ok_c;
    logic             res_ok_c;
    logic             mis_c;

    // Handshakes depend only on the registered occupancy.
    assign bus.push_ready = (count_q != CNT_W'(DEPTH));
    assign bus.res_ready  = (count_q != CNT_W'(0));

    assign bus.count      = count_q;
    assign bus.upd_addr   = upd_addr_q;
    assign bus.upd_taken  = upd_taken_q;
    assign bus.upd_we     = upd_we_q;
    assign bus.mispredict = mispredict_q;

    // Accept decisions and the mispredict condition for the oldest entry.
    always_comb begin
        head_c    = mem[rd_ptr];
        push_ok_c = bus.push_valid && bus.push_ready;
        res_ok_c  = bus.res_valid && bus.res_ready;
        mis_c     = res_ok_c && (bus.res_taken ^ head_c.pred);
    end

    // Next occupancy: a mispredict empties the queue and drops any same-cycle push.
    always_comb begin
        count_nxt_c = count_q;
        if (mis_c) begin
            count_nxt_c = '0;
        end else if (push_ok_c && !res_ok_c) begin
            count_nxt_c = count_q + CNT_W'(1);
        end else if (!push_ok_c && res_ok_c) begin
            count_nxt_c = count_q - CNT_W'(1);
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_nxt_c;
            if (res_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (mis_c) begin
                wr_ptr <= rd_ptr + PTR_W'(1);
            end else if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage; wrong-path pushes never land.
    always_ff @(posedge clk) begin
        if (push_ok_c && !mis_c) begin
            mem[wr_ptr] <= '{idx: bus.push_idx, pred: bus.push_pred};
        end
    end

    // Registered predictor write port and mispredict pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_addr_q   <= '0;
            upd_taken_q  <= 1'b0;
            upd_we_q     <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            upd_we_q     <= res_ok_c;
            mispredict_q <= mis_c;
            if (res_ok_c) begin
                upd_addr_q  <= head_c.idx;
                upd_taken_q <= bus.res_taken;
            end
        end
    end
endmodule

// File: tb/tb_bp_resolve.sv
// Scoreboard bench for bp_resolve: a queue model predicts each update.
module tb_bp_resolve;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDX_W = 8;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
    } ent_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic             mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bp_resolve_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    bp_resolve #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic pv, input logic [IDX_W-1:0] pidx, input logic ppred,
                         input logic rv, input logic rt);
        logic push_ok;
        logic res_ok;
        ent_t h;
        exp_t e;
        bus.push_valid = pv;
        bus.push_idx   = pidx;
        bus.push_pred  = ppred;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        check("push_ready", 32'(bus.push_ready), 32'(mq.size() != DEPTH));
        check("res_ready",  32'(bus.res_ready),  32'(mq.size() != 0));
        push_ok = pv && (mq.size() != DEPTH);
        res_ok  = rv && (mq.size() != 0);
        if (res_ok) begin
            h = mq.pop_front();
            e = '{idx: h.idx, taken: rt, mis: rt ^ h.pred};
            sb.push_back(e);
            if (e.mis) mq.delete();
            else if (push_ok) mq.push_back('{idx: pidx, pred: ppred});
        end else if (push_ok) begin
            mq.push_back('{idx: pidx, pred: ppred});
        end
        @(posedge clk);
        #1;
        if (res_ok) begin
            e = sb.pop_front();
            check("upd_we",     32'(bus.upd_we),     32'd1);
            check("upd_addr",   32'(bus.upd_addr),   32'(e.idx));
            check("upd_taken",  32'(bus.upd_taken),  32'(e.taken));
            check("mispredict", 32'(bus.mispredict), 32'(e.mis));
        end else begin
            check("upd_we_idle", 32'(bus.upd_we),     32'd0);
            check("mis_idle",    32'(bus.mispredict), 32'd0);
        end
        check("count", 32'(bus.count), 32'(mq.size()));
    endtask

    task automatic idle_inputs();
        bus.push_valid = 1'b0;
        bus.push_idx   = '0;
        bus.push_pred  = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        // Reset held for 3 cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count",      32'(bus.count),      32'd0);
        check("rst_push_ready", 32'(bus.push_ready), 32'd1);
        check("rst_res_ready",  32'(bus.res_ready),  32'd0);
        check("rst_upd_we",     32'(bus.upd_we),     32'd0);
        check("rst_mispredict", 32'(bus.mispredict), 32'd0);
        check("rst_upd_addr",   32'(bus.upd_addr),   32'd0);
        rst_n = 1'b1;

        // Fill, then a 9th push that must be refused.
        for (int i = 0; i < 8; i++) cycle(1'b1, IDX_W'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        check("full_count", 32'(bus.count), 32'd8);

        // In-order drain, back-to-back updates.
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("drain_res_ready", 32'(bus.res_ready), 32'd0);

        // Empty: a resolve is ignored even alongside a push.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Full: a resolve does not let a same-cycle push in.
        for (int i = 0; i < 8; i++) cycle(1'b1, IDX_W'(8'h60 + i), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h6f, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Mispredict flush with a wrong-path push in the same cycle.
        cycle(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h13, 1'b0, 1'b1, 1'b0);
        check("flush_count", 32'(bus.count), 32'd0);
        cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Steady state at depth 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, IDX_W'(8'ha0 + i), 1'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, IDX_W'(8'h30 + i), 1'(i % 3 == 0), 1'b1, mq[0].pred);
        end
        check("steady_count", 32'(bus.count), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, mq[0].pred);

        // Async reset mid-stream with an update in flight.
        for (int i = 0; i < 5; i++) cycle(1'b1, IDX_W'(8'hc0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hc5, 1'b0, 1'b1, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd5);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",     32'(bus.count),      32'd0);
        check("arst_upd_we",    32'(bus.upd_we),     32'd0);
        check("arst_res_ready", 32'(bus.res_ready),  32'd0);
        mq.delete();
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_resolve.md
# bp_resolve

Branch-resolution tracker that sits directly downstream of the branch predictor cache and drives that cache's write port. Fetch pushes one entry per predicted branch: the predictor index and the predicted direction. Execute resolves branches in program order with the actual outcome. The block pops the oldest entry, emits a registered predictor update (address, outcome, write enable) plus a mispredict pulse, and flushes all younger wrong-path entries on a mispredict.

## Interface
Parameters:
- DEPTH, 8, number of in-flight branches tracked; power of two, at least 2
- IDX_W, 8, width of the predictor index; matches the predictor's 256-entry table

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- push_valid  in  1  fetch presents a predicted branch
- push_idx  in  IDX_W  predictor index of the branch
- push_pred  in  1  predicted direction (1 = taken)
- push_ready  out  1  combinational, equals count != DEPTH
- res_valid  in  1  execute presents the outcome of the oldest branch
- res_taken  in  1  actual direction
- res_ready  out  1  combinational, equals count != 0
- upd_addr  out  IDX_W  registered, predictor write index
- upd_taken  out  1  registered, outcome to train with (predictor did_branch)
- upd_we  out  1  registered, one-cycle write-enable pulse (predictor we)
- mispredict  out  1  registered, one-cycle pulse when outcome != prediction
- count  out  $clog2(DEPTH)+1  registered, number of valid entries

## Operation
- Storage: circular FIFO of {idx, pred} with head pointer (rd_ptr), tail pointer (wr_ptr) and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push accept: push_valid && push_ready. Writes the entry at wr_ptr, then wr_ptr+1 and count+1.
- Resolve accept: res_valid && res_ready. Reads the head, then rd_ptr+1 and count-1.
- On the edge after a resolve accept:
  - upd_we=1, upd_addr=head.idx, upd_taken=res_taken.
  - mispredict = res_taken ^ head.pred.
- No resolve accepted in a cycle -> upd_we=0 and mispredict=0 on the next edge. upd_addr and upd_taken hold their last value.
- Mispredict flush: on the same edge where a mispredicting resolve is accepted:
  - count=0 and wr_ptr=rd_ptr+1, so the queue is empty.
  - A push accepted in that same cycle is discarded; it is wrong-path.
- Simultaneous push and correct resolve: both take effect, count unchanged, FIFO order preserved.
- Full: push_ready=0, so a push is not accepted even if a resolve is accepted in the same cycle. There is no full bypass.
- Empty: res_ready=0 and res_valid is ignored, including when a push arrives in the same cycle. There is no empty bypass.
- Reset values: count=0, rd_ptr=0, wr_ptr=0, upd_we=0, upd_addr=0, upd_taken=0, mispredict=0. This gives push_ready=1 and res_ready=0.
- Storage contents need no reset.

## Timing
- Resolve to update latency is exactly 1 cycle. Back-to-back resolves give back-to-back upd_we pulses at one per cycle.
- The predictor's synchronous read sees the trained counter 2 cycles after the resolve accept: 1 cycle for this block, 1 for the predictor write.
- push_ready and res_ready depend only on registered count. They have no combinational path from push_valid or res_valid.
- Async reset mid-operation clears all registers immediately, without waiting for an edge. Any update in flight is dropped (upd_we=0).
- Operation resumes on the first rising edge after rst_n deasserts.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> count=0, push_ready=1, res_ready=0, upd_we=0, mispredict=0.
- Fill and overflow: push idx 0..7 with pred=0 -> count=8, push_ready=0. A 9th push with idx 0x08 is ignored: count stays 8 and 0x08 never appears on upd_addr.
- In-order drain: resolve 8 times with res_taken=0 on consecutive cycles -> 8 consecutive upd_we pulses, upd_addr 0..7 in order, upd_taken=0, mispredict=0 throughout, count=0 and res_ready=0 at the end.
- Mispredict flush: push 0x10/pred 1, 0x11/pred 1, 0x12/pred 0. Resolve with res_taken=0 while also pushing 0x13 -> next cycle upd_addr=0x10, upd_taken=0, mispredict=1, count=0. A later push of 0x20 followed by its resolve yields upd_addr=0x20.
- Steady-state wrap: keep count=3 and push plus correctly resolve every cycle for 20 cycles with idx 0x30..0x43 -> count stays 3, upd_addr follows the pushed order exactly across pointer wrap, mispredict=0.
- Async reset mid-stream: with count=5, drop rst_n between clock edges -> count=0 and upd_we=0 immediately. After release, res_ready=0 and the first new push resolves with the correct upd_addr.
